// File: rtl/operand_fetch_stage_pkg.sv
// Shared widths, bypass-select encodings and the ID/EX register payload.
package operand_fetch_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CTRL_W = 16;

  localparam logic [REG_AW-1:0] REG_ZERO = REG_AW'(0);

  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_EX   = 2'd1,
    SEL_WB   = 2'd2,
    SEL_RF   = 2'd3
  } byp_sel_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [REG_AW-1:0] dest;
    logic              we;
    logic              is_load;
    logic [CTRL_W-1:0] ctrl;
  } idex_t;

  // True when a real (non-r0) source register names the given destination.
  function automatic logic reg_hit(input logic [REG_AW-1:0] src,
                                   input logic [REG_AW-1:0] dst);
    return (src != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// ID-side, register-file, forwarding and ID/EX bundle of the operand stage.
interface operand_fetch_stage_if #(
  parameter int unsigned CNT_W = 32
);
  import operand_fetch_stage_pkg::*;

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [REG_AW-1:0] id_dest;
  logic              id_we;
  logic              id_is_load;
  logic [CTRL_W-1:0] id_ctrl;

  logic [REG_AW-1:0] rf_ra1;
  logic [REG_AW-1:0] rf_ra2;
  logic [DATA_W-1:0] rf_rd1;
  logic [DATA_W-1:0] rf_rd2;

  logic [DATA_W-1:0] ex_result;
  logic              wb_we;
  logic [REG_AW-1:0] wb_wa;
  logic [DATA_W-1:0] wb_wd;

  logic              ex_stall;
  logic              flush;
  logic              id_stall;

  logic              ex_valid;
  logic [DATA_W-1:0] ex_op_a;
  logic [DATA_W-1:0] ex_op_b;
  logic [REG_AW-1:0] ex_dest;
  logic              ex_we;
  logic              ex_is_load;
  logic [CTRL_W-1:0] ex_ctrl;

  logic [CNT_W-1:0]  load_use_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest, id_we, id_is_load, id_ctrl,
    output rf_rd1, rf_rd2, ex_result, wb_we, wb_wa, wb_wd, ex_stall, flush,
    input  rf_ra1, rf_ra2, id_stall,
    input  ex_valid, ex_op_a, ex_op_b, ex_dest, ex_we, ex_is_load, ex_ctrl, load_use_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest, id_we, id_is_load, id_ctrl,
    input  rf_rd1, rf_rd2, ex_result, wb_we, wb_wa, wb_wd, ex_stall, flush,
    output rf_ra1, rf_ra2, id_stall,
    output ex_valid, ex_op_a, ex_op_b, ex_dest, ex_we, ex_is_load, ex_ctrl, load_use_cnt
  );

endinterface

// File: rtl/operand_fetch_stage_operand_bypass.sv
// Per-operand forwarding mux: r0, then EX result, then WB write data, then register file.
module operand_fetch_stage_operand_bypass
  import operand_fetch_stage_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic              ex_fwd_en,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_wa,
  input  logic [DATA_W-1:0] wb_wd,
  input  logic [DATA_W-1:0] rf_rd,
  output logic [DATA_W-1:0] operand_c
);

  byp_sel_e sel;

  // Pick the youngest producer of src; loads in EX are never forwarded.
  always_comb begin
    sel = SEL_RF;
    if (src == REG_ZERO) begin
      sel = SEL_ZERO;
    end else if (ex_fwd_en && (ex_dest == src)) begin
      sel = SEL_EX;
    end else if (wb_we && (wb_wa == src)) begin
      sel = SEL_WB;
    end
  end

  // Steer the selected source onto the operand.
  always_comb begin
    operand_c = '0;
    case (sel)
      SEL_ZERO: operand_c = '0;
      SEL_EX:   operand_c = ex_result;
      SEL_WB:   operand_c = wb_wd;
      default:  operand_c = rf_rd;
    endcase
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: register file addressing, bypass, load-use hazard, ID/EX register, stall counter.
module operand_fetch_stage #(
  parameter int unsigned CNT_W = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  operand_fetch_stage_if.slave bus
);
  import operand_fetch_stage_pkg::*;

  idex_t             ex_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              hazard_c;
  logic              ex_fwd_en_c;
  logic [DATA_W-1:0] op_a_c;
  logic [DATA_W-1:0] op_b_c;

  assign bus.rf_ra1 = bus.id_rs;
  assign bus.rf_ra2 = bus.id_rt;

  assign ex_fwd_en_c = ex_q.valid && ex_q.we && !ex_q.is_load;

  operand_fetch_stage_operand_bypass u_byp_a (
    .src       (bus.id_rs),
    .ex_fwd_en (ex_fwd_en_c),
    .ex_dest   (ex_q.dest),
    .ex_result (bus.ex_result),
    .wb_we     (bus.wb_we),
    .wb_wa     (bus.wb_wa),
    .wb_wd     (bus.wb_wd),
    .rf_rd     (bus.rf_rd1),
    .operand_c (op_a_c)
  );

  operand_fetch_stage_operand_bypass u_byp_b (
    .src       (bus.id_rt),
    .ex_fwd_en (ex_fwd_en_c),
    .ex_dest   (ex_q.dest),
    .ex_result (bus.ex_result),
    .wb_we     (bus.wb_we),
    .wb_wa     (bus.wb_wa),
    .wb_wd     (bus.wb_wd),
    .rf_rd     (bus.rf_rd2),
    .operand_c (op_b_c)
  );

  // A load in EX whose result the ID instruction needs cannot be forwarded yet.
  always_comb begin
    hazard_c = 1'b0;
    if (bus.id_valid && ex_q.valid && ex_q.is_load && ex_q.we) begin
      hazard_c = (bus.id_uses_rs && reg_hit(bus.id_rs, ex_q.dest)) ||
                 (bus.id_uses_rt && reg_hit(bus.id_rt, ex_q.dest));
    end
  end

  assign bus.id_stall = bus.ex_stall || hazard_c;

  // ID/EX register: hold on EX stall, squash on flush or hazard, else capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else if (bus.ex_stall) begin
      ex_q <= ex_q;
    end else if (bus.flush || hazard_c) begin
      ex_q.valid <= 1'b0;
      ex_q.we    <= 1'b0;
    end else begin
      ex_q.valid   <= bus.id_valid;
      ex_q.op_a    <= op_a_c;
      ex_q.op_b    <= op_b_c;
      ex_q.dest    <= bus.id_dest;
      ex_q.we      <= bus.id_we && bus.id_valid;
      ex_q.is_load <= bus.id_is_load;
      ex_q.ctrl    <= bus.id_ctrl;
    end
  end

  // Saturating count of cycles lost to load-use bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (hazard_c && !bus.ex_stall && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_op_a      = ex_q.op_a;
  assign bus.ex_op_b      = ex_q.op_b;
  assign bus.ex_dest      = ex_q.dest;
  assign bus.ex_we        = ex_q.we;
  assign bus.ex_is_load   = ex_q.is_load;
  assign bus.ex_ctrl      = ex_q.ctrl;
  assign bus.load_use_cnt = cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for the operand fetch stage with hand-computed expectations.
module tb_operand_fetch_stage;
  import operand_fetch_stage_pkg::*;

  localparam int unsigned TB_CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  operand_fetch_stage_if #(.CNT_W(TB_CNT_W)) bus ();

  operand_fetch_stage #(.CNT_W(TB_CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.id_valid = 1'b0; bus.id_rs = '0; bus.id_rt = '0;
    bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0; bus.id_dest = '0;
    bus.id_we = 1'b0; bus.id_is_load = 1'b0; bus.id_ctrl = '0;
    bus.rf_rd1 = '0; bus.rf_rd2 = '0; bus.ex_result = '0;
    bus.wb_we = 1'b0; bus.wb_wa = '0; bus.wb_wd = '0;
    bus.ex_stall = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dest,
                          input logic is_load, input logic [15:0] ctrl);
    bus.id_valid = 1'b1; bus.id_rs = rs; bus.id_rt = rt;
    bus.id_uses_rs = 1'b1; bus.id_uses_rt = 1'b1; bus.id_dest = dest;
    bus.id_we = 1'b1; bus.id_is_load = is_load; bus.id_ctrl = ctrl;
  endtask

  initial begin
    // Reset with random inputs
    rst_n = 1'b0;
    bus.id_valid = 1'b1; bus.id_rs = 5'($urandom); bus.id_rt = 5'($urandom);
    bus.id_uses_rs = 1'b1; bus.id_uses_rt = 1'b1; bus.id_dest = 5'($urandom);
    bus.id_we = 1'b1; bus.id_is_load = 1'b1; bus.id_ctrl = 16'($urandom);
    bus.rf_rd1 = $urandom; bus.rf_rd2 = $urandom; bus.ex_result = $urandom;
    bus.wb_we = 1'b1; bus.wb_wa = 5'($urandom); bus.wb_wd = $urandom;
    bus.ex_stall = 1'b0; bus.flush = 1'b0;
    repeat (3) tick();
    check_eq("rst_valid", 64'(bus.ex_valid), 64'h0);
    check_eq("rst_op_a", 64'(bus.ex_op_a), 64'h0);
    check_eq("rst_op_b", 64'(bus.ex_op_b), 64'h0);
    check_eq("rst_dest", 64'(bus.ex_dest), 64'h0);
    check_eq("rst_we", 64'(bus.ex_we), 64'h0);
    check_eq("rst_is_load", 64'(bus.ex_is_load), 64'h0);
    check_eq("rst_ctrl", 64'(bus.ex_ctrl), 64'h0);
    check_eq("rst_cnt", 64'(bus.load_use_cnt), 64'h0);
    set_idle();
    rst_n = 1'b1;

    // add r3, r1, r2 from the register file
    drive_id(5'd1, 5'd2, 5'd3, 1'b0, 16'h00A5);
    bus.rf_rd1 = 32'h5; bus.rf_rd2 = 32'h6;
    #1;
    check_eq("ra1", 64'(bus.rf_ra1), 64'd1);
    check_eq("ra2", 64'(bus.rf_ra2), 64'd2);
    tick();
    check_eq("add_valid", 64'(bus.ex_valid), 64'h1);
    check_eq("add_op_a", 64'(bus.ex_op_a), 64'h5);
    check_eq("add_op_b", 64'(bus.ex_op_b), 64'h6);
    check_eq("add_dest", 64'(bus.ex_dest), 64'd3);
    check_eq("add_ctrl", 64'(bus.ex_ctrl), 64'h00A5);

    // add r7, r3, r2: r3 forwarded from EX
    drive_id(5'd3, 5'd2, 5'd7, 1'b0, 16'h0001);
    bus.rf_rd1 = 32'h0; bus.rf_rd2 = 32'h6; bus.ex_result = 32'h11;
    #1;
    check_eq("exbyp_no_stall", 64'(bus.id_stall), 64'h0);
    tick();
    check_eq("exbyp_op_a", 64'(bus.ex_op_a), 64'h11);
    check_eq("exbyp_op_b", 64'(bus.ex_op_b), 64'h6);

    // r0 / r5 with WB writing r5
    drive_id(5'd0, 5'd5, 5'd8, 1'b0, 16'h0002);
    bus.rf_rd1 = 32'h77; bus.rf_rd2 = 32'h1234;
    bus.wb_we = 1'b1; bus.wb_wa = 5'd5; bus.wb_wd = 32'hABCD;
    tick();
    check_eq("wbbyp_op_a_r0", 64'(bus.ex_op_a), 64'h0);
    check_eq("wbbyp_op_b", 64'(bus.ex_op_b), 64'hABCD);

    // reading r0 while WB targets r0 must still give zero; dest r9
    drive_id(5'd0, 5'd0, 5'd9, 1'b0, 16'h0003);
    bus.rf_rd1 = 32'h55; bus.rf_rd2 = 32'h66;
    bus.wb_we = 1'b1; bus.wb_wa = 5'd0; bus.wb_wd = 32'hFFFF;
    tick();
    check_eq("r0_op_a", 64'(bus.ex_op_a), 64'h0);
    check_eq("r0_op_b", 64'(bus.ex_op_b), 64'h0);

    // EX beats WB for r9
    drive_id(5'd9, 5'd9, 5'd10, 1'b0, 16'h0004);
    bus.wb_we = 1'b1; bus.wb_wa = 5'd9; bus.wb_wd = 32'hBEEF;
    bus.ex_result = 32'hCAFE; bus.rf_rd1 = 32'h1; bus.rf_rd2 = 32'h2;
    tick();
    check_eq("prio_op_a", 64'(bus.ex_op_a), 64'hCAFE);
    check_eq("prio_op_b", 64'(bus.ex_op_b), 64'hCAFE);

    // lw r4 then add r6, r4, r4
    set_idle();
    drive_id(5'd1, 5'd0, 5'd4, 1'b1, 16'h0010);
    bus.id_uses_rt = 1'b0;
    #1;
    check_eq("lw_no_stall", 64'(bus.id_stall), 64'h0);
    tick();
    check_eq("lw_is_load", 64'(bus.ex_is_load), 64'h1);
    drive_id(5'd4, 5'd4, 5'd6, 1'b0, 16'h0020);
    bus.rf_rd1 = 32'h77; bus.rf_rd2 = 32'h77; bus.ex_result = 32'hDEAD;
    #1;
    check_eq("lu_stall", 64'(bus.id_stall), 64'h1);
    tick();
    check_eq("lu_bubble_valid", 64'(bus.ex_valid), 64'h0);
    check_eq("lu_bubble_we", 64'(bus.ex_we), 64'h0);
    check_eq("lu_cnt", 64'(bus.load_use_cnt), 64'h1);
    bus.wb_we = 1'b1; bus.wb_wa = 5'd4; bus.wb_wd = 32'h4444;
    #1;
    check_eq("lu_stall_clear", 64'(bus.id_stall), 64'h0);
    tick();
    check_eq("lu_add_valid", 64'(bus.ex_valid), 64'h1);
    check_eq("lu_add_op_a", 64'(bus.ex_op_a), 64'h4444);
    check_eq("lu_add_op_b", 64'(bus.ex_op_b), 64'h4444);
    check_eq("lu_add_dest", 64'(bus.ex_dest), 64'd6);
    check_eq("lu_cnt_hold", 64'(bus.load_use_cnt), 64'h1);

    // EX stall with flush for three cycles holds the register
    set_idle();
    drive_id(5'd1, 5'd2, 5'd8, 1'b0, 16'h0030);
    bus.rf_rd1 = 32'h99;
    bus.ex_stall = 1'b1; bus.flush = 1'b1;
    #1;
    check_eq("st_id_stall", 64'(bus.id_stall), 64'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("st_hold_valid", 64'(bus.ex_valid), 64'h1);
      check_eq("st_hold_op_a", 64'(bus.ex_op_a), 64'h4444);
      check_eq("st_hold_dest", 64'(bus.ex_dest), 64'd6);
    end
    bus.ex_stall = 1'b0;
    #1;
    check_eq("st_release_stall", 64'(bus.id_stall), 64'h0);
    tick();
    check_eq("flush_valid", 64'(bus.ex_valid), 64'h0);
    check_eq("flush_we", 64'(bus.ex_we), 64'h0);

    // alternate lw r4 / dependent add to build up hazard cycles
    bus.flush = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_id(5'd1, 5'd0, 5'd4, 1'b1, 16'h0040);
      bus.id_uses_rt = 1'b0;
      tick();
      drive_id(5'd4, 5'd2, 5'd6, 1'b0, 16'h0050);
      tick();
      if (i == 9) check_eq("sat_cnt_mid", 64'(bus.load_use_cnt), 64'd11);
    end
    check_eq("sat_cnt", 64'(bus.load_use_cnt), 64'd15);

    // reset asserted while a load-use stall is pending
    drive_id(5'd1, 5'd0, 5'd4, 1'b1, 16'h0060);
    bus.id_uses_rt = 1'b0;
    tick();
    drive_id(5'd4, 5'd4, 5'd6, 1'b0, 16'h0070);
    #1;
    check_eq("mid_pre_stall", 64'(bus.id_stall), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(bus.ex_valid), 64'h0);
    check_eq("mid_rst_cnt", 64'(bus.load_use_cnt), 64'h0);
    check_eq("mid_rst_stall", 64'(bus.id_stall), 64'h0);
    tick();
    rst_n = 1'b1;
    bus.rf_rd1 = 32'h21; bus.rf_rd2 = 32'h22;
    tick();
    check_eq("post_rst_valid", 64'(bus.ex_valid), 64'h1);
    check_eq("post_rst_op_a", 64'(bus.ex_op_a), 64'h21);
    check_eq("post_rst_op_b", 64'(bus.ex_op_b), 64'h22);
    check_eq("post_rst_cnt", 64'(bus.load_use_cnt), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
